// File: rtl/pipeline_hazard_control.sv
// Backward hazard control for the five-stage pipeline: load-use stalls, multi-cycle
// taken-branch flushes and data-memory-busy freezes. Optional counters: PIPELINE_HAZARD_STALL_COUNTERS_EN.
module pipeline_hazard_control #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_reg_write,
  input  logic                      branch_taken,
  input  logic                      mem_busy,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      id_ex_hold,
  output logic                      ex_mem_hold,
  output logic                      id_ex_bubble,
  output logic                      mem_wb_bubble,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      flushing,
  output logic [31:0]               stall_count,
  output logic [31:0]               flush_count,
  output logic                      fsm_state
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter must hold FLUSH_CYCLES-1; keep at least one bit when FLUSH_CYCLES is 1 or 2.
  localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          load_use;
  logic          branch_accept;

  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    branch_accept = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    flushing      = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        // Whole front of the pipe waits; EX re-presents branch/load-use once released.
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
        flushing      = (state == FLUSH);
      end else begin
        unique case (state)
          RUN: begin
            if (branch_taken) begin
              if_id_flush   = 1'b1;
              id_ex_flush   = 1'b1;
              branch_accept = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = CNT_LOAD;
              end
            end else if (load_use) begin
              pc_hold      = 1'b1;
              if_id_hold   = 1'b1;
              id_ex_bubble = 1'b1;
            end
          end
          FLUSH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flushing    = 1'b1;
            cnt_next    = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
              state_next = RUN;
              cnt_next   = '0;
            end
          end
          default: begin
            state_next = RUN;
            cnt_next   = '0;
          end
        endcase
      end
    end
  end

  assign fsm_state = (state == FLUSH) & ~reset;

`ifdef PIPELINE_HAZARD_STALL_COUNTERS_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold)       stall_q <= stall_q + 32'd1;
      if (branch_accept) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_count = reset ? 32'd0 : stall_q;
  assign flush_count = reset ? 32'd0 : flush_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule
